// File: rtl/mac_scale_engine.sv
// mac_scale_engine: per-vector accumulation of a*mu with a saturated, fixed-point-scaled result.
// Optional build macro MAC_SCALE_ROUND_EN selects round-half-up instead of floor before the shift.
module mac_scale_engine #(
  parameter int CNT_LEN    = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(CNT_LEN) + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         enable_i,
  input  logic [DATA_WIDTH-1:0]        mu_i,
  input  logic [$clog2(CNT_LEN):0]     len_i,
  input  logic                         a_valid_i,
  output logic                         a_ready_o,
  input  logic [DATA_WIDTH-1:0]        a_data_i,
  output logic                         d_valid_o,
  input  logic                         d_ready_i,
  output logic [DATA_WIDTH-1:0]        d_data_o,
  output logic [$clog2(CNT_LEN):0]     cnt_out_o
);
  localparam int CW = $clog2(CNT_LEN) + 1;
  localparam int PW = 2*DATA_WIDTH;

  typedef enum logic [1:0] {ST_ACC = 2'd0, ST_DRAIN = 2'd1, ST_OUT = 2'd2} state_t;

  state_t                      state_r, state_nxt_s;
  logic signed [PW-1:0]        prod_r, prod_s;
  logic                        p1_valid_r;
  logic signed [ACC_WIDTH-1:0] acc_r, acc_sum_s, acc_rnd_s, acc_shift_s;
  logic [CW-1:0]               cnt_r, cnt_inc_s;
  logic                        d_valid_r;
  logic [DATA_WIDTH-1:0]       d_data_r;
  logic                        a_ready_s, a_fire_s, d_fire_s;

  function automatic logic [DATA_WIDTH-1:0] sat_fn(input logic signed [ACC_WIDTH-1:0] v);
    logic [ACC_WIDTH-DATA_WIDTH:0] upper;
    upper = v[ACC_WIDTH-1:DATA_WIDTH-1];
    if ((&upper) || !(|upper)) sat_fn = v[DATA_WIDTH-1:0];
    else if (v[ACC_WIDTH-1])   sat_fn = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                       sat_fn = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

  // Handshake qualification and next-state selection.
  always_comb begin
    a_ready_s   = 1'b0;
    state_nxt_s = state_r;
    cnt_inc_s   = cnt_r + CW'(1);
    if (rst_ni && enable_i && !clear_i && (state_r == ST_ACC) && (len_i != {CW{1'b0}}))
      a_ready_s = 1'b1;
    else
      a_ready_s = 1'b0;
    a_fire_s = a_ready_s & a_valid_i;
    d_fire_s = d_valid_r & d_ready_i & enable_i & ~clear_i;
    case (state_r)
      ST_ACC:   if (a_fire_s && (cnt_inc_s == len_i)) state_nxt_s = ST_DRAIN;
                else                                  state_nxt_s = ST_ACC;
      ST_DRAIN: state_nxt_s = ST_OUT;
      ST_OUT:   if (d_fire_s) state_nxt_s = ST_ACC;
                else          state_nxt_s = ST_OUT;
      default:  state_nxt_s = ST_ACC;
    endcase
  end

  // Product, accumulate, optional rounding and scaling shift.
  always_comb begin
    prod_s = $signed(a_data_i) * $signed(mu_i);
    if (p1_valid_r) acc_sum_s = acc_r + {{(ACC_WIDTH-PW){prod_r[PW-1]}}, prod_r};
    else            acc_sum_s = acc_r;
`ifdef MAC_SCALE_ROUND_EN
    acc_rnd_s = acc_sum_s + {{(ACC_WIDTH-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
`else
    acc_rnd_s = acc_sum_s;
`endif
    acc_shift_s = acc_rnd_s >>> FRAC_BITS;
  end

  // State register; clear forces a fresh vector, disable freezes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       state_r <= ST_ACC;
    else if (clear_i)  state_r <= ST_ACC;
    else if (enable_i) state_r <= state_nxt_s;
    else               state_r <= state_r;
  end

  // Stage-1 product pipe, accumulator, element count and output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_r     <= {PW{1'b0}};
      p1_valid_r <= 1'b0;
      acc_r      <= {ACC_WIDTH{1'b0}};
      cnt_r      <= {CW{1'b0}};
      d_valid_r  <= 1'b0;
      d_data_r   <= {DATA_WIDTH{1'b0}};
    end else if (clear_i) begin
      p1_valid_r <= 1'b0;
      acc_r      <= {ACC_WIDTH{1'b0}};
      cnt_r      <= {CW{1'b0}};
      d_valid_r  <= 1'b0;
    end else if (enable_i) begin
      p1_valid_r <= a_fire_s;
      if (a_fire_s) begin
        prod_r <= prod_s;
        cnt_r  <= cnt_inc_s;
      end
      if (d_fire_s) begin
        acc_r     <= {ACC_WIDTH{1'b0}};
        cnt_r     <= {CW{1'b0}};
        d_valid_r <= 1'b0;
      end else begin
        acc_r <= acc_sum_s;
      end
      // DRAIN folds in the last product and publishes the scaled result in one step.
      if (state_r == ST_DRAIN) begin
        d_valid_r <= 1'b1;
        d_data_r  <= sat_fn(acc_shift_s);
      end
    end
  end

  assign a_ready_o = a_ready_s;
  assign d_valid_o = d_valid_r;
  assign d_data_o  = d_data_r;
  assign cnt_out_o = cnt_r;
endmodule
